// File: rtl/freq_hist_if.sv
// freq_hist_if: sample-stream and readout bus between the frequency counter
// side (master) and the histogram accumulator (slave).
interface freq_hist_if #(
    parameter int BIN_W = 20
);
    logic [15:0]      diff_stream;
    logic             diff_stream_strobe;
    logic [3:0]       rd_addr;
    logic [BIN_W-1:0] rd_data;

    modport master (
        output diff_stream,
        output diff_stream_strobe,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  diff_stream,
        input  diff_stream_strobe,
        input  rd_addr,
        output rd_data
    );
endinterface

// File: rtl/freq_hist.sv
// freq_hist: 16-bin saturating histogram of the 4-bit per-cycle count
// differences carried in the frequency counter's diff_stream words.
// A window of 2^WINDOW_LOG2 strobed words is accumulated after each arm,
// then the bins are frozen for host readout through rd_addr/rd_data.
// Optional feature macro: FREQ_HIST_MINMAX_EN enables min/max nibble tracking;
// without it min_val and max_val are tied to 4'h0.
module freq_hist #(
    parameter int BIN_W       = 20,
    parameter int WINDOW_LOG2 = 16
) (
    input  logic         usbclk,
    input  logic         rst_n,
    freq_hist_if.slave   bus,
    input  logic         arm,
    output logic         busy,
    output logic         done,
    output logic         sat,
    output logic [3:0]   min_val,
    output logic [3:0]   max_val
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_DONE
    } state_t;

    // Exact terminal count; the extra counter bit means no wrap is ever relied on.
    localparam logic [WINDOW_LOG2:0] WIN_TERM = {1'b1, {WINDOW_LOG2{1'b0}}};
    // Sums carry three guard bits so bin + (0..4) never overflows before the clamp.
    localparam int                   SUM_W    = BIN_W + 3;
    localparam logic [SUM_W-1:0]     BIN_MAX  = {3'b000, {BIN_W{1'b1}}};

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sat_q, sat_d;
    logic [WINDOW_LOG2:0] win_cnt_q, win_cnt_d;
    logic [WINDOW_LOG2:0] win_cnt_inc;
    logic [BIN_W-1:0]     bins_q [16];
    logic [BIN_W-1:0]     bins_d [16];
    logic [BIN_W-1:0]     rd_data_q, rd_data_d;
    logic [SUM_W-1:0]     sum;

    // Number of nibbles in a word equal to a given bin index (0..4).
    function automatic logic [2:0] count_matches(input logic [15:0] word, input logic [3:0] b);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (word[4*k +: 4] == b) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

    // Next-state logic: arm clears and (re)starts from any state, strobes in ACQ are binned.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        sat_d       = sat_q;
        win_cnt_d   = win_cnt_q;
        bins_d      = bins_q;
        rd_data_d   = bins_q[bus.rd_addr];
        win_cnt_inc = win_cnt_q + 1'b1;
        sum         = '0;
        if (arm) begin
            state_d   = ST_ACQ;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            sat_d     = 1'b0;
            win_cnt_d = '0;
            for (int b = 0; b < 16; b++) begin
                bins_d[b] = '0;
            end
        end else if (state_q == ST_ACQ && bus.diff_stream_strobe) begin
            for (int b = 0; b < 16; b++) begin
                sum = {3'b000, bins_q[b]} + SUM_W'(count_matches(bus.diff_stream, 4'(b)));
                if (sum > BIN_MAX) begin
                    bins_d[b] = {BIN_W{1'b1}};
                    sat_d     = 1'b1;
                end else begin
                    bins_d[b] = sum[BIN_W-1:0];
                end
            end
            win_cnt_d = win_cnt_inc;
            if (win_cnt_inc == WIN_TERM) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    // State, bins, status flags and the registered readout port.
    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            win_cnt_q <= '0;
            rd_data_q <= '0;
            for (int b = 0; b < 16; b++) begin
                bins_q[b] <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
            win_cnt_q <= win_cnt_d;
            rd_data_q <= rd_data_d;
            for (int b = 0; b < 16; b++) begin
                bins_q[b] <= bins_d[b];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sat         = sat_q;
    assign bus.rd_data = rd_data_q;

`ifdef FREQ_HIST_MINMAX_EN
    logic [3:0] min_q, min_d;
    logic [3:0] max_q, max_d;
    logic [3:0] nib;

    // Extreme-nibble tracking follows exactly the same accept condition as the bins.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        nib   = 4'h0;
        if (arm) begin
            min_d = 4'hF;
            max_d = 4'h0;
        end else if (state_q == ST_ACQ && bus.diff_stream_strobe) begin
            for (int k = 0; k < 4; k++) begin
                nib = bus.diff_stream[4*k +: 4];
                if (nib < min_d) begin
                    min_d = nib;
                end
                if (nib > max_d) begin
                    max_d = nib;
                end
            end
        end
    end

    // Min/max registers start from the "nothing seen" extremes.
    always_ff @(posedge usbclk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 4'hF;
            max_q <= 4'h0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
`else
    assign min_val = 4'h0;
    assign max_val = 4'h0;
`endif

endmodule

// File: tb/tb_freq_hist.sv
// tb_freq_hist: randomized and directed stimulus for freq_hist, checked by a
// queue-based scoreboard against a bin-counting reference model.
module tb_freq_hist;

    localparam int BIN_W       = 5;
    localparam int WINDOW_LOG2 = 3;
    localparam int WIN         = 1 << WINDOW_LOG2;
    localparam int BIN_MAX     = (1 << BIN_W) - 1;

    logic       usbclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       arm    = 1'b0;
    logic       busy;
    logic       done;
    logic       sat;
    logic [3:0] min_val;
    logic [3:0] max_val;

    freq_hist_if #(.BIN_W(BIN_W)) bus ();

    freq_hist #(
        .BIN_W       (BIN_W),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) dut (
        .usbclk  (usbclk),
        .rst_n   (rst_n),
        .bus     (bus),
        .arm     (arm),
        .busy    (busy),
        .done    (done),
        .sat     (sat),
        .min_val (min_val),
        .max_val (max_val)
    );

    // 100 MHz-style free-running clock.
    always #5 usbclk = ~usbclk;

    typedef struct {
        int rd_data;
        int busy;
        int done;
        int sat;
        int min_v;
        int max_v;
        int step;
    } expect_t;

    expect_t expect_q[$];
    int      errors  = 0;
    int      checks  = 0;
    int      step_no = 0;
    bit      running = 1'b0;

    // Reference model: plain per-bin counts with a clamp, and window bookkeeping.
    int m_bins [16];
    bit m_acq;
    bit m_done;
    bit m_sat;
    int m_min;
    int m_max;
    int m_cnt;

    function automatic int exp_min();
`ifdef FREQ_HIST_MINMAX_EN
        return m_min;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_max();
`ifdef FREQ_HIST_MINMAX_EN
        return m_max;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 16; b++) m_bins[b] = 0;
        m_sat = 1'b0;
        m_min = 15;
        m_max = 0;
        m_cnt = 0;
    endtask

    task automatic push_expect(input int rd_val);
        expect_t e;
        e.rd_data = rd_val;
        e.busy    = int'(m_acq);
        e.done    = int'(m_done);
        e.sat     = int'(m_sat);
        e.min_v   = exp_min();
        e.max_v   = exp_max();
        e.step    = step_no;
        expect_q.push_back(e);
        step_no++;
    endtask

    task automatic applyReset();
        @(negedge usbclk);
        running = 1'b1;
        rst_n   = 1'b0;
        arm     = 1'b0;
        bus.diff_stream_strobe = 1'b0;
        model_clear();
        m_acq  = 1'b0;
        m_done = 1'b0;
        push_expect(0);
    endtask

    // One clock of stimulus; the model advances as the DUT will at the next edge.
    task automatic applyStimulus(input bit do_arm, input bit do_strobe,
                                 input logic [15:0] word, input logic [3:0] addr);
        int rd_val;
        int nib;
        @(negedge usbclk);
        rst_n                  = 1'b1;
        arm                    = do_arm;
        bus.diff_stream_strobe = do_strobe;
        bus.diff_stream        = word;
        bus.rd_addr            = addr;
        rd_val = m_bins[addr];
        if (do_arm) begin
            model_clear();
            m_acq  = 1'b1;
            m_done = 1'b0;
        end else if (m_acq && do_strobe) begin
            for (int k = 0; k < 4; k++) begin
                nib = int'((word >> (4 * k)) & 16'hF);
                if (m_bins[nib] == BIN_MAX) m_sat = 1'b1;
                else m_bins[nib] = m_bins[nib] + 1;
                if (nib < m_min) m_min = nib;
                if (nib > m_max) m_max = nib;
            end
            m_cnt = m_cnt + 1;
            if (m_cnt == WIN) begin
                m_acq  = 1'b0;
                m_done = 1'b1;
            end
        end
        push_expect(rd_val);
    endtask

    task automatic check_val(input string name, input int act, input int exp_v, input int step);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, step, act, exp_v);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        check_val("rd_data", int'(bus.rd_data), e.rd_data, e.step);
        check_val("busy",    int'(busy),        e.busy,    e.step);
        check_val("done",    int'(done),        e.done,    e.step);
        check_val("sat",     int'(sat),         e.sat,     e.step);
        check_val("min_val", int'(min_val),     e.min_v,   e.step);
        check_val("max_val", int'(max_val),     e.max_v,   e.step);
    endtask

    // Monitor: each edge the DUT presents one new output set; compare against the oldest expectation.
    always @(posedge usbclk) begin
        #2;
        if (expect_q.size() > 0) begin
            checkOutput(expect_q.pop_front());
        end else if (running) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got no expectation, required one per edge");
        end
    end

    task automatic sweep(input bit strobe_on);
        for (int a = 0; a < 16; a++) applyStimulus(1'b0, strobe_on, 16'($urandom), 4'(a));
    endtask

    initial begin
        bus.diff_stream        = 16'h0;
        bus.diff_stream_strobe = 1'b0;
        bus.rd_addr            = 4'h0;

        applyReset();

        // Strobes while idle must not touch the bins.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 16'($urandom), 4'(i));

        // Uniform window of ones: bin 1 saturates, then strobes in DONE are ignored.
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h1);
        for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, 16'h1111, 4'h1);
        sweep(1'b1);

        // Mixed pattern covering nibble 0 and 15.
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        applyStimulus(1'b0, 1'b1, 16'h0123, 4'h0);
        applyStimulus(1'b0, 1'b1, 16'h3333, 4'h3);
        applyStimulus(1'b0, 1'b1, 16'h2F00, 4'hF);
        applyStimulus(1'b0, 1'b1, 16'h1111, 4'h1);
        for (int i = 0; i < WIN - 4; i++) applyStimulus(1'b0, 1'b1, 16'($urandom), 4'(i));
        sweep(1'b0);

        // Restart mid-window: the strobe coinciding with arm is dropped.
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h2);
        applyStimulus(1'b0, 1'b1, 16'h2222, 4'h2);
        applyStimulus(1'b0, 1'b1, 16'h2222, 4'h2);
        applyStimulus(1'b1, 1'b1, 16'h7777, 4'h7);
        for (int i = 0; i < WIN; i++) applyStimulus(1'b0, 1'b1, 16'h3333, 4'(i % 4 + 2));
        sweep(1'b0);

        // Randomized windows with a live readout sweep, restarts and a reset pulse.
        for (int w = 0; w < 6; w++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
            for (int c = 0; c < 60 && !m_done; c++) begin
                if (w == 3 && c == 9) begin
                    applyReset();
                end else begin
                    applyStimulus((w == 4 && c == 5), (w % 2 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0),
                                  16'($urandom), 4'(c % 16));
                end
            end
            sweep(1'b1);
        end

        // Reset pulse partway through an acquisition, then idle strobes.
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h4321, 4'(i + 1));
        applyReset();
        sweep(1'b1);

        @(posedge usbclk);
        #3;
        if (expect_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expect_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_hist.md
# freq_hist

Histogram accumulator for the Gray-code frequency counter's sample stream, in the `usbclk` domain. Each strobed 16-bit `diff_stream` word holds four 4-bit per-cycle count differences. The block bins every nibble into 16 saturating counters over a window of 2^WINDOW_LOG2 strobes, then holds the result for host readout by address. It sits directly downstream of the frequency counter and lets the host see cycle-to-cycle jitter and glitches that the 28-bit `frequency` average hides.

## Interface
- BIN_W, 20: width of each bin counter.
- WINDOW_LOG2, 16: acquisition window is 2^WINDOW_LOG2 strobed words, i.e. 4·2^WINDOW_LOG2 nibbles.
- usbclk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- diff_stream  in  16  four packed 4-bit differences; [3:0] newest, [15:12] oldest.
- diff_stream_strobe  in  1  word valid this cycle.
- arm  in  1  single-cycle start pulse; clears bins and begins acquisition.
- busy  out  1  high while acquiring.
- done  out  1  high once a window completes; held until next arm.
- rd_addr  in  4  bin index to read.
- rd_data  out  BIN_W  registered content of bin rd_addr.
- sat  out  1  sticky: some bin saturated during the current/last window.
- min_val  out  4  smallest nibble seen this window (see Configuration).
- max_val  out  4  largest nibble seen this window (see Configuration).

## Operation
- States: IDLE, ACQ, DONE.
- Reset values:
  - State IDLE; all bins 0.
  - busy 0, done 0, sat 0, rd_data 0.
  - min_val 4'hF, max_val 4'h0.
- IDLE or DONE, arm=1 → ACQ next cycle, with these updates in the same edge:
  - All 16 bins cleared; window counter cleared.
  - sat cleared; min_val/max_val set to reset values.
- ACQ, strobe=1:
  - Each bin b adds the number of nibbles equal to b (0..4); duplicate nibbles within a word all count.
  - Window counter increments.
  - On the 2^WINDOW_LOG2-th strobe, the bins update and the state goes to DONE.
- ACQ, arm=1 → restart: same clear as from IDLE. Any strobe in that cycle is discarded and not binned. State stays ACQ.
- Saturation: a bin whose sum would exceed 2^BIN_W−1 holds at 2^BIN_W−1 and sets sat. No wrap-around.
- DONE: bins frozen; strobes ignored.
- Window counter is WINDOW_LOG2+1 bits wide; terminal count is compared exactly, never by wrap.
- Readout is independent of state. It may read live bins during ACQ; values are then the pre-update contents of that cycle.
- rst_n asserted mid-window: immediate return to reset values; the partial histogram is lost.

## Timing
- arm at edge N: busy=1, done=0 and bins=0 visible after edge N. The first countable strobe is sampled at edge N+1.
- Strobe sampled at edge N: the bin increment is visible on rd_data two edges later (bin update at N, rd_data register at N+1), provided rd_addr is held.
- rd_data latency: 1 cycle from rd_addr.
- Final strobe at edge N: busy falls and done rises after edge N.
- Strobes may be back-to-back every cycle; no throughput limit. The upstream block's typical rate is 1 per 4 cycles.
- Sum of all bins after a full window = 4·2^WINDOW_LOG2, unless sat=1.

## Configuration
- FREQ_HIST_MINMAX_EN defined:
  - min_val/max_val track the extreme nibble over all binned nibbles of the window.
  - Both update on the same edge as the bins and hold in DONE.
- Not defined:
  - Tracking logic is omitted; min_val and max_val are constant 4'h0.
  - The histogram is unaffected.

## Test plan
- WINDOW_LOG2=2, arm, then 4 strobes of 16'h1111 → done=1 after the 4th strobe; bin1=16, all other bins 0; sat=0.
- WINDOW_LOG2=2, strobes of 16'h0123, 16'h3333, 16'h2F00, 16'h1111 → bin0=3, bin1=5, bin2=2, bin3=5, bin15=1. With FREQ_HIST_MINMAX_EN: min_val=0, max_val=15.
- BIN_W=4, WINDOW_LOG2=3, 8 strobes of 16'h5555 → bin5=15 (saturated), sat=1, done=1.
- Arm, 2 strobes of 16'h2222, then arm together with a strobe of 16'h7777, then a full window of 16'h3333 → bin2=0, bin7=0, bin3=4·2^WINDOW_LOG2.
- Strobes in IDLE and DONE, and rst_n pulsed low mid-ACQ → bins unchanged while idle/done. After the reset pulse: all bins 0, busy=0, done=0, min_val=4'hF, max_val=0 (min_val=0 without the macro).
- Continuous readout sweep of rd_addr 0..15 during ACQ with every-cycle strobes → rd_data matches the model delayed by the 2-edge rule; no lost increments.
